// File: rtl/md_iter_pkg.sv
// Shared op codes, FSM states and op-class helpers for the iterative mult/div unit.
// MD_MACC_EN adds the multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) to the multiply class.
package md_iter_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [3:0] code);
    return (code == OP_DIV) || (code == OP_DIVU);
  endfunction

  function automatic logic op_is_macc(input logic [3:0] code);
    return (code == OP_MADD) || (code == OP_MADDU) ||
           (code == OP_MSUB) || (code == OP_MSUBU);
  endfunction

  function automatic logic op_is_sub(input logic [3:0] code);
    return (code == OP_MSUB) || (code == OP_MSUBU);
  endfunction

  // Ops that run through the shift-add multiplier.
  function automatic logic op_is_mul(input logic [3:0] code);
`ifdef MD_MACC_EN
    return (code == OP_MULT) || (code == OP_MULTU) || op_is_macc(code);
`else
    return (code == OP_MULT) || (code == OP_MULTU);
`endif
  endfunction

  function automatic logic op_is_signed(input logic [3:0] code);
    return (code == OP_MULT) || (code == OP_DIV) ||
           (code == OP_MADD) || (code == OP_MSUB);
  endfunction

endpackage

// File: rtl/md_core.sv
// One combinational step of the iterative datapath: a shift-add multiply bit
// or a restoring-divide bit, selected by div_mode.
module md_core #(
  parameter int WIDTH = 32
) (
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    addend  = acc[0] ? m : {WIDTH{1'b0}};
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    // Partial remainder picks up the next dividend bit from the quotient half.
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    fits    = (rem_sh >= {1'b0, m});
    // When the divisor fits, the true difference is below m, so W bits suffice.
    diff    = rem_sh[WIDTH-1:0] - m;
    if (div_mode) begin
      if (fits) acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      else      acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/md_iter.sv
// Iterative multiply/divide unit with HI/LO registers, one result bit per cycle.
// Define MD_MACC_EN to add MADD/MADDU/MSUB/MSUBU accumulation into {hi,lo}.
module md_iter
  import md_iter_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg;
  logic [3:0]         op_reg;
  logic               neg_p_reg, neg_r_reg;
  logic [WIDTH-1:0]   m_reg, hi_reg, lo_reg;
  logic [2*WIDTH-1:0] acc_reg, acc_step;
  logic               done_reg, dz_reg;

  logic               iter_accept, mt_accept, last_iter, signed_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem, hi_fix, lo_fix;
  logic               dz_fix;

  assign iter_accept = (state_reg == S_IDLE) && start && (op_is_mul(op) || op_is_div(op));
  assign mt_accept   = (state_reg == S_IDLE) && start && ((op == OP_MTHI) || (op == OP_MTLO));
  assign last_iter   = (count_reg == CNT_W'(WIDTH - 1));
  assign signed_op   = op_is_signed(op);
  assign mag_a       = (signed_op && a[WIDTH-1]) ? -a : a;
  assign mag_b       = (signed_op && b[WIDTH-1]) ? -b : b;

  md_core #(.WIDTH(WIDTH)) u_core (
    .div_mode (op_is_div(op_reg)),
    .acc      (acc_reg),
    .m        (m_reg),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (iter_accept) state_next = S_CALC;
      S_CALC:  if (last_iter)   state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Sign correction and result selection applied in FIX.
  always_comb begin
    prod   = neg_p_reg ? -acc_reg : acc_reg;
    quot   = neg_p_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem    = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    dz_fix = op_is_div(op_reg) && (m_reg == {WIDTH{1'b0}});
    hi_fix = hi_reg;
    lo_fix = lo_reg;
    if (op_is_div(op_reg)) begin
      // With a zero divisor every quotient bit sets and the remainder is |a|,
      // so re-signing it hands back the original dividend.
      lo_fix = dz_fix ? {WIDTH{1'b1}} : quot;
      hi_fix = rem;
    end
`ifdef MD_MACC_EN
    else if (op_is_macc(op_reg)) begin
      if (op_is_sub(op_reg)) {hi_fix, lo_fix} = {hi_reg, lo_reg} - prod;
      else                   {hi_fix, lo_fix} = {hi_reg, lo_reg} + prod;
    end
`endif
    else begin
      {hi_fix, lo_fix} = prod;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      op_reg    <= '0;
      neg_p_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      m_reg     <= '0;
      acc_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (iter_accept) begin
        op_reg    <= op;
        count_reg <= '0;
        dz_reg    <= 1'b0;
        neg_p_reg <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r_reg <= signed_op && a[WIDTH-1];
        // Divide keeps the divisor in m; multiply keeps the multiplicand there.
        if (op_is_div(op)) begin
          m_reg   <= mag_b;
          acc_reg <= {{WIDTH{1'b0}}, mag_a};
        end else begin
          m_reg   <= mag_a;
          acc_reg <= {{WIDTH{1'b0}}, mag_b};
        end
      end else if (mt_accept) begin
        if (op == OP_MTHI) hi_reg <= a;
        else               lo_reg <= a;
        dz_reg   <= 1'b0;
        done_reg <= 1'b1;
      end
      if (state_reg == S_CALC) begin
        acc_reg   <= acc_step;
        count_reg <= count_reg + CNT_W'(1);
      end
      if (state_reg == S_FIX) begin
        hi_reg   <= hi_fix;
        lo_reg   <= lo_fix;
        dz_reg   <= dz_fix;
        done_reg <= 1'b1;
      end
    end
  end

  assign busy = (state_reg != S_IDLE);
  assign done = done_reg;
  assign dz   = dz_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_md_iter.sv
// Self-checking bench for md_iter: directed cases plus random ops against a 64-bit arithmetic model.
// Define MD_MACC_EN to exercise the accumulate ops as well.
module tb_md_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] hi_m = '0, lo_m = '0;
  logic         dz_m = 1'b0;

  logic [3:0]   dt_op [4] = '{4'd3, 4'd2, 4'd2, 4'd3};
  logic [W-1:0] dt_a  [4] = '{32'd100, 32'hFFFFFFF9, 32'h80000000, 32'h12345678};
  logic [W-1:0] dt_b  [4] = '{32'd7, 32'd2, 32'hFFFFFFFF, 32'd0};
  logic [W-1:0] dt_hi [4] = '{32'd2, 32'hFFFFFFFF, 32'd0, 32'h12345678};
  logic [W-1:0] dt_lo [4] = '{32'd14, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
  logic         dt_dz [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  md_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Architectural meaning of each op, computed with wide arithmetic.
  task automatic model(input logic [3:0] opc, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] ps, pu, acc;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ps  = sx * sy;
    pu  = {32'b0, x} * {32'b0, y};
    acc = {hi_m, lo_m};
    dz_m = 1'b0;
    case (opc)
      4'd0: {hi_m, lo_m} = ps;
      4'd1: {hi_m, lo_m} = pu;
      4'd2, 4'd3: begin
        if (y == 0) begin
          lo_m = '1; hi_m = x; dz_m = 1'b1;
        end else if (opc == 4'd2) begin
          q = sx / sy; r = sx % sy;
          lo_m = q[31:0]; hi_m = r[31:0];
        end else begin
          lo_m = x / y; hi_m = x % y;
        end
      end
      4'd4: hi_m = x;
      4'd5: lo_m = x;
      4'd8:  {hi_m, lo_m} = acc + ps;
      4'd9:  {hi_m, lo_m} = acc + pu;
      4'd10: {hi_m, lo_m} = acc - ps;
      4'd11: {hi_m, lo_m} = acc - pu;
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at the negedge where done is seen (lat 0 = cycle after accept).
  task automatic do_op(input logic [3:0] opc, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output int busy_cnt, output logic dz0);
    start = 1'b1; op = opc; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 0; busy_cnt = 0; dz0 = dz;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (busy) busy_cnt++;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b lat=%0d", opc, x, y, hi, lo, dz, lat);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, dz} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, dz}); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, dz, hi, lo} !== '0) begin errors++; $display("FAIL post_reset: got %h expected 0", {busy, done, dz, hi, lo}); end
  endtask

  task automatic test_mult();
    int lat, bc; logic d0;
    model(4'd0, 32'hFFFFFFFD, 32'd5);
    do_op(4'd0, 32'hFFFFFFFD, 32'd5, lat, bc, d0);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency: got %0d expected 33", lat); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL mult_busy: got %0d expected 33", bc); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_neg: got %h_%h expected ffffffff_fffffff1", hi, lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", done); end
    model(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, d0);
    checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin errors++; $display("FAIL multu_max: got %h_%h expected fffffffe_00000001", hi, lo); end
  endtask

  task automatic test_mt();
    int lat, bc; logic d0; logic [W-1:0] x;
    model(4'd4, 32'hA5A5A5A5, 32'd0);
    do_op(4'd4, 32'hA5A5A5A5, $urandom, lat, bc, d0);
    checks++; if (lat !== 0 || bc !== 0) begin errors++; $display("FAIL mthi_timing: got lat=%0d busy=%0d expected 0 0", lat, bc); end
    checks++; if (hi !== 32'hA5A5A5A5 || lo !== 32'h00000001) begin errors++; $display("FAIL mthi_value: got %h_%h expected a5a5a5a5_00000001", hi, lo); end
    x = $urandom;
    model(4'd5, x, 32'd0);
    do_op(4'd5, x, $urandom, lat, bc, d0);
    checks++; if (hi !== 32'hA5A5A5A5 || lo !== x) begin errors++; $display("FAIL mtlo_value: got %h_%h expected a5a5a5a5_%h", hi, lo, x); end
  endtask

  task automatic test_div();
    int lat, bc; logic d0;
    for (int i = 0; i < 4; i++) begin
      model(dt_op[i], dt_a[i], dt_b[i]);
      do_op(dt_op[i], dt_a[i], dt_b[i], lat, bc, d0);
      checks++; if (lat !== 33) begin errors++; $display("FAIL div%0d_latency: got %0d expected 33", i, lat); end
      checks++; if (hi !== dt_hi[i] || lo !== dt_lo[i] || dz !== dt_dz[i])
        begin errors++; $display("FAIL div%0d_result: got %h_%h dz=%b expected %h_%h dz=%b", i, hi, lo, dz, dt_hi[i], dt_lo[i], dt_dz[i]); end
    end
    model(4'd0, 32'd6, 32'd7);
    do_op(4'd0, 32'd6, 32'd7, lat, bc, d0);
    checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL dz_clear_at_accept: got %b expected 0", d0); end
    checks++; if (lo !== 32'd42 || dz !== 1'b0) begin errors++; $display("FAIL mult_after_dz: got lo=%h dz=%b expected 2a 0", lo, dz); end
  endtask

  task automatic test_random();
    int lat, bc, sel; logic d0; logic [3:0] opc; logic [W-1:0] x, y;
    for (int i = 0; i < 120; i++) begin
      opc = 4'($urandom_range(0, 5));
      sel = $urandom_range(0, 7);
      x = $urandom; y = $urandom;
      if (sel == 0) y = '0;
      else if (sel == 1) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      else if (sel == 2) begin x = $urandom_range(0, 300) - 150; y = $urandom_range(0, 40) - 20; end
      model(opc, x, y);
      do_op(opc, x, y, lat, bc, d0);
      checks++; if (lat !== ((opc < 4) ? 33 : 0) || bc !== ((opc < 4) ? 33 : 0))
        begin errors++; $display("FAIL rand%0d_timing: got lat=%0d busy=%0d expected %0d", i, lat, bc, (opc < 4) ? 33 : 0); end
      checks++; if (hi !== hi_m || lo !== lo_m || dz !== dz_m)
        begin errors++; $display("FAIL rand%0d_op%0d: got %h_%h dz=%b expected %h_%h dz=%b", i, opc, hi, lo, dz, hi_m, lo_m, dz_m); end
    end
  endtask

  task automatic test_back_to_back();
    int c; logic [W-1:0] x, y, x2, y2;
    x = $urandom; y = $urandom; x2 = $urandom; y2 = $urandom;
    start = 1'b1; op = 4'd0; a = x; b = y;
    @(negedge clk);
    start = 1'b0; c = 0;
    while (!done && c < 100) begin
      if (c == 5) begin start = 1'b1; op = 4'd3; a = $urandom; b = $urandom; end
      else start = 1'b0;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    model(4'd0, x, y);
    $display("b2b op=0 a=%h b=%h -> hi=%h lo=%h lat=%0d", x, y, hi, lo, c);
    checks++; if (c !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", c); end
    checks++; if (hi !== hi_m || lo !== lo_m) begin errors++; $display("FAIL b2b_mult: got %h_%h expected %h_%h", hi, lo, hi_m, lo_m); end
    // Issue the next op in the very cycle done is seen.
    start = 1'b1; op = 4'd1; a = x2; b = y2;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_reissue: got busy=%b expected 1", busy); end
    c = 0;
    while (!done && c < 100) begin @(negedge clk); c++; end
    model(4'd1, x2, y2);
    $display("b2b op=1 a=%h b=%h -> hi=%h lo=%h lat=%0d", x2, y2, hi, lo, c);
    checks++; if (c !== 33 || hi !== hi_m || lo !== lo_m)
      begin errors++; $display("FAIL b2b_multu: got %h_%h lat=%0d expected %h_%h lat=33", hi, lo, c, hi_m, lo_m); end
  endtask

  task automatic test_undef();
    int lat, bc, seen; logic d0; logic [W-1:0] y;
    y = $urandom | 32'h1;
    model(4'd3, y, 32'd0);
    do_op(4'd3, y, 32'd0, lat, bc, d0);
    for (int k = 6; k < 16; k++) begin
`ifdef MD_MACC_EN
      if (k >= 8 && k <= 11) continue;
`endif
      start = 1'b1; op = 4'(k); a = $urandom; b = $urandom;
      @(negedge clk);
      start = 1'b0; seen = 0;
      for (int c = 0; c < 36; c++) begin
        if (busy || done) seen++;
        @(negedge clk);
      end
      $display("undef op=%0d -> hi=%h lo=%h dz=%0b", k, hi, lo, dz);
      checks++; if (seen !== 0) begin errors++; $display("FAIL undef%0d_activity: got %0d busy/done cycles expected 0", k, seen); end
      checks++; if (hi !== hi_m || lo !== lo_m || dz !== dz_m)
        begin errors++; $display("FAIL undef%0d_state: got %h_%h dz=%b expected %h_%h dz=%b", k, hi, lo, dz, hi_m, lo_m, dz_m); end
    end
  endtask

  task automatic test_macc();
`ifdef MD_MACC_EN
    int lat, bc; logic d0; logic [3:0] opc; logic [W-1:0] x, y;
    model(4'd4, 32'd0, 32'd0);  do_op(4'd4, 32'd0, 32'd0, lat, bc, d0);
    model(4'd5, 32'd10, 32'd0); do_op(4'd5, 32'd10, 32'd0, lat, bc, d0);
    model(4'd8, 32'hFFFFFFFE, 32'd3);
    do_op(4'd8, 32'hFFFFFFFE, 32'd3, lat, bc, d0);
    checks++; if (lat !== 33 || hi !== 32'd0 || lo !== 32'd4 || dz !== 1'b0)
      begin errors++; $display("FAIL madd: got %h_%h lat=%0d expected 00000000_00000004 lat=33", hi, lo, lat); end
    model(4'd11, 32'd3, 32'd3);
    do_op(4'd11, 32'd3, 32'd3, lat, bc, d0);
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFB)
      begin errors++; $display("FAIL msubu: got %h_%h expected ffffffff_fffffffb", hi, lo); end
    for (int i = 0; i < 20; i++) begin
      opc = 4'($urandom_range(8, 11)); x = $urandom; y = $urandom;
      model(opc, x, y);
      do_op(opc, x, y, lat, bc, d0);
      checks++; if (lat !== 33 || hi !== hi_m || lo !== lo_m || dz !== 1'b0)
        begin errors++; $display("FAIL macc%0d_op%0d: got %h_%h lat=%0d expected %h_%h lat=33", i, opc, hi, lo, lat, hi_m, lo_m); end
    end
`endif
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen; logic d0; logic [W-1:0] x;
    x = $urandom | 32'h1;
    model(4'd4, x, 32'd0); do_op(4'd4, x, 32'd0, lat, bc, d0);
    model(4'd5, x, 32'd0); do_op(4'd5, x, 32'd0, lat, bc, d0);
    start = 1'b1; op = 4'd2; a = $urandom; b = $urandom | 32'h1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    $display("reset mid-div -> busy=%0b hi=%h lo=%h", busy, hi, lo);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0)
      begin errors++; $display("FAIL midreset_flags: got busy=%b done=%b dz=%b expected 000", busy, done, dz); end
    checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL midreset_hilo: got %h_%h expected 0_0", hi, lo); end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy || done) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0 || hi !== '0 || lo !== '0)
      begin errors++; $display("FAIL midreset_quiet: got %0d active cycles hi=%h lo=%h expected 0", seen, hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mt();
    test_div();
    test_random();
    test_back_to_back();
    test_undef();
    test_macc();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
